// File: rtl/ras_ctrl.sv
// Return-address-stack pointer controller: speculative/architectural TOS tracking and array port drive.
// Optional: define RAS_UNDERFLOW_GUARD_EN to freeze pointers on pops of an empty stack.
`timescale 1ns/1ps
module ras_ctrl #(
    parameter int DEPTH = 16,
    parameter int INDEX = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             specPush_i,
    input  logic [WIDTH-1:0] specPushAddr_i,
    input  logic             specPop_i,
    input  logic             archPush_i,
    input  logic [WIDTH-1:0] archPushAddr_i,
    input  logic             archPop_i,
    input  logic             recover_i,
    input  logic [WIDTH-1:0] ramData_i,
    output logic [INDEX-1:0] rasAddr0_o,
    output logic [INDEX-1:0] rasAddr0wr_o,
    output logic [WIDTH-1:0] rasData0wr_o,
    output logic             rasWe0_o,
    output logic [INDEX-1:0] rasAddr1wr_o,
    output logic [WIDTH-1:0] rasData1wr_o,
    output logic             rasWe1_o,
    output logic             rasRecover_o,
    output logic [WIDTH-1:0] predTarget_o,
    output logic             predValid_o,
    output logic [INDEX:0]   specCount_o
);

    localparam logic [INDEX:0]   CNT_FULL = (INDEX+1)'(DEPTH);
    localparam logic [INDEX:0]   CNT_ONE  = (INDEX+1)'(1);
    localparam logic [INDEX-1:0] TOS_ONE  = INDEX'(1);

    logic [INDEX-1:0] r_specTos;
    logic [INDEX-1:0] r_archTos;
    logic [INDEX:0]   r_specCnt;
    logic [INDEX:0]   r_archCnt;
    logic             r_recoverDly;

    logic             w_sPush;
    logic             w_sPop;
    logic             w_aPush;
    logic             w_aPop;
    logic [INDEX-1:0] w_specTosNxt;
    logic [INDEX:0]   w_specCntNxt;
    logic [INDEX-1:0] w_archTosNxt;
    logic [INDEX:0]   w_archCntNxt;

    // Shared pointer/count update for both stacks; push+pop replaces the top entry in place.
    function automatic logic [2*INDEX:0] f_next(
        input logic             push,
        input logic             pop,
        input logic [INDEX-1:0] tos,
        input logic [INDEX:0]   cnt
    );
        logic [INDEX-1:0] n_tos;
        logic [INDEX:0]   n_cnt;
        n_tos = tos;
        n_cnt = cnt;
        case ({push, pop})
            2'b10: begin
                n_tos = tos + TOS_ONE;
                if (cnt != CNT_FULL) n_cnt = cnt + CNT_ONE;
            end
            2'b01: begin
`ifdef RAS_UNDERFLOW_GUARD_EN
                if (cnt != '0) begin
                    n_tos = tos - TOS_ONE;
                    n_cnt = cnt - CNT_ONE;
                end
`else
                n_tos = tos - TOS_ONE;
                if (cnt != '0) n_cnt = cnt - CNT_ONE;
`endif
            end
            2'b11: begin
                if (cnt == '0) n_cnt = CNT_ONE;
            end
            default: ;
        endcase
        return {n_tos, n_cnt};
    endfunction

    always_comb begin
        w_sPush = specPush_i & ~recover_i;
        w_sPop  = specPop_i  & ~recover_i;
        w_aPush = archPush_i & ~recover_i;
        w_aPop  = archPop_i  & ~recover_i;
        {w_specTosNxt, w_specCntNxt} = f_next(w_sPush, w_sPop, r_specTos, r_specCnt);
        {w_archTosNxt, w_archCntNxt} = f_next(w_aPush, w_aPop, r_archTos, r_archCnt);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_specTos    <= '0;
            r_archTos    <= '0;
            r_specCnt    <= '0;
            r_archCnt    <= '0;
            r_recoverDly <= 1'b0;
        end else begin
            r_recoverDly <= recover_i;
            r_archTos    <= w_archTosNxt;
            r_archCnt    <= w_archCntNxt;
            if (recover_i) begin
                r_specTos <= r_archTos;
                r_specCnt <= r_archCnt;
            end else begin
                r_specTos <= w_specTosNxt;
                r_specCnt <= w_specCntNxt;
            end
        end
    end

    // Combinational outputs are held at zero while reset is asserted.
    always_comb begin
        rasAddr0_o   = r_specTos;
        specCount_o  = r_specCnt;
        rasWe0_o     = reset & w_sPush;
        rasAddr0wr_o = reset ? (w_sPop ? r_specTos : r_specTos + TOS_ONE) : '0;
        rasData0wr_o = reset ? specPushAddr_i : '0;
        rasWe1_o     = reset & w_aPush;
        rasAddr1wr_o = reset ? (w_aPop ? r_archTos : r_archTos + TOS_ONE) : '0;
        rasData1wr_o = reset ? archPushAddr_i : '0;
        rasRecover_o = reset & recover_i;
        predTarget_o = reset ? ramData_i : '0;
`ifdef RAS_UNDERFLOW_GUARD_EN
        predValid_o  = reset & (r_specCnt != '0) & ~recover_i & ~r_recoverDly;
`else
        predValid_o  = reset & ~recover_i & ~r_recoverDly;
`endif
    end

endmodule

// File: tb/tb_ras_ctrl.sv
// Scoreboard bench for ras_ctrl: directed vectors queue expected outputs, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_ras_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        specPush_i = 1'b0;
    logic [31:0] specPushAddr_i = '0;
    logic        specPop_i = 1'b0;
    logic        archPush_i = 1'b0;
    logic [31:0] archPushAddr_i = '0;
    logic        archPop_i = 1'b0;
    logic        recover_i = 1'b0;
    logic [31:0] ramData_i;
    logic [3:0]  rasAddr0_o;
    logic [3:0]  rasAddr0wr_o;
    logic [31:0] rasData0wr_o;
    logic        rasWe0_o;
    logic [3:0]  rasAddr1wr_o;
    logic [31:0] rasData1wr_o;
    logic        rasWe1_o;
    logic        rasRecover_o;
    logic [31:0] predTarget_o;
    logic        predValid_o;
    logic [4:0]  specCount_o;

    ras_ctrl #(.DEPTH(16), .INDEX(4), .WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .specPush_i(specPush_i), .specPushAddr_i(specPushAddr_i), .specPop_i(specPop_i),
        .archPush_i(archPush_i), .archPushAddr_i(archPushAddr_i), .archPop_i(archPop_i),
        .recover_i(recover_i), .ramData_i(ramData_i),
        .rasAddr0_o(rasAddr0_o),
        .rasAddr0wr_o(rasAddr0wr_o), .rasData0wr_o(rasData0wr_o), .rasWe0_o(rasWe0_o),
        .rasAddr1wr_o(rasAddr1wr_o), .rasData1wr_o(rasData1wr_o), .rasWe1_o(rasWe1_o),
        .rasRecover_o(rasRecover_o), .predTarget_o(predTarget_o), .predValid_o(predValid_o),
        .specCount_o(specCount_o)
    );

    always #5 clk = ~clk;

    // Array model: speculative copy plus architectural checkpoint restored on recover.
    logic [31:0] spec_mem [16];
    logic [31:0] arch_mem [16];
    assign ramData_i = spec_mem[rasAddr0_o];

    always @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 16; k++) begin
                spec_mem[k] <= '0;
                arch_mem[k] <= '0;
            end
        end else if (rasRecover_o) begin
            for (int k = 0; k < 16; k++) spec_mem[k] <= arch_mem[k];
        end else begin
            if (rasWe1_o) begin
                arch_mem[rasAddr1wr_o] <= rasData1wr_o;
                spec_mem[rasAddr1wr_o] <= rasData1wr_o;
            end
            if (rasWe0_o) spec_mem[rasAddr0wr_o] <= rasData0wr_o;
        end
    end

    always @(negedge clk) begin
        if (reset && recover_i)
            assert (!archPush_i && !archPop_i) else $error("commit op during recover");
    end

    typedef struct {
        bit          rst;
        logic [3:0]  tos;
        logic [4:0]  cnt;
        bit          we0;
        logic [3:0]  a0;
        logic [31:0] d0;
        bit          we1;
        logic [3:0]  a1;
        logic [31:0] d1;
        bit          rec;
        bit          pv;
        logic [31:0] tgt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    bit   prev_rec = 1'b0;

`ifdef RAS_UNDERFLOW_GUARD_EN
    localparam logic [3:0] EMPTY_POP_TOS = 4'd0;
`else
    localparam logic [3:0] EMPTY_POP_TOS = 4'd15;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: one expectation per driven cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("rasAddr0", 32'(rasAddr0_o), 32'(e.tos));
                chk("specCount", 32'(specCount_o), 32'(e.cnt));
                chk("rasWe0", 32'(rasWe0_o), 32'(e.we0));
                chk("rasWe1", 32'(rasWe1_o), 32'(e.we1));
                chk("rasRecover", 32'(rasRecover_o), 32'(e.rec));
                chk("predValid", 32'(predValid_o), 32'(e.pv));
                if (e.rst) begin
                    chk("rst_addr0wr", 32'(rasAddr0wr_o), 32'd0);
                    chk("rst_data0wr", rasData0wr_o, 32'd0);
                    chk("rst_addr1wr", 32'(rasAddr1wr_o), 32'd0);
                    chk("rst_data1wr", rasData1wr_o, 32'd0);
                    chk("rst_predTarget", predTarget_o, 32'd0);
                end else begin
                    if (e.we0) begin
                        chk("rasAddr0wr", 32'(rasAddr0wr_o), 32'(e.a0));
                        chk("rasData0wr", rasData0wr_o, e.d0);
                    end
                    if (e.we1) begin
                        chk("rasAddr1wr", 32'(rasAddr1wr_o), 32'(e.a1));
                        chk("rasData1wr", rasData1wr_o, e.d1);
                    end
                    if (e.pv) chk("predTarget", predTarget_o, e.tgt);
                end
            end
        end
    end

    function automatic bit pv_model(input logic [4:0] cnt, input bit rec, input bit rdly);
`ifdef RAS_UNDERFLOW_GUARD_EN
        return (cnt != 5'd0) && !rec && !rdly;
`else
        return !rec && !rdly;
`endif
    endfunction

    task automatic step(input bit sp, input logic [31:0] spa, input bit so,
                        input bit ap, input logic [31:0] apa, input bit ao, input bit rec,
                        input logic [3:0] e_tos, input logic [4:0] e_cnt,
                        input bit e_we0, input logic [3:0] e_a0,
                        input bit e_we1, input logic [3:0] e_a1, input logic [31:0] e_tgt);
        exp_t e;
        @(posedge clk);
        #1;
        reset = 1'b1;
        specPush_i = sp; specPushAddr_i = spa; specPop_i = so;
        archPush_i = ap; archPushAddr_i = apa; archPop_i = ao;
        recover_i = rec;
        e.rst = 1'b0; e.tos = e_tos; e.cnt = e_cnt;
        e.we0 = e_we0; e.a0 = e_a0; e.d0 = spa;
        e.we1 = e_we1; e.a1 = e_a1; e.d1 = apa;
        e.rec = rec; e.pv = pv_model(e_cnt, rec, prev_rec); e.tgt = e_tgt;
        q.push_back(e);
        prev_rec = rec;
    endtask

    task automatic spush(input logic [31:0] a, input logic [3:0] tos, input logic [4:0] cnt,
                         input logic [3:0] a0, input logic [31:0] tgt);
        step(1, a, 0, 0, 0, 0, 0, tos, cnt, 1, a0, 0, 0, tgt);
    endtask

    task automatic spop(input logic [3:0] tos, input logic [4:0] cnt, input logic [31:0] tgt);
        step(0, 0, 1, 0, 0, 0, 0, tos, cnt, 0, 0, 0, 0, tgt);
    endtask

    task automatic idle(input logic [3:0] tos, input logic [4:0] cnt, input logic [31:0] tgt);
        step(0, 0, 0, 0, 0, 0, 0, tos, cnt, 0, 0, 0, 0, tgt);
    endtask

    task automatic push_rst_exp();
        exp_t e;
        e.rst = 1'b1; e.tos = '0; e.cnt = '0; e.we0 = 0; e.a0 = '0; e.d0 = '0;
        e.we1 = 0; e.a1 = '0; e.d1 = '0; e.rec = 0; e.pv = 0; e.tgt = '0;
        q.push_back(e);
        prev_rec = 1'b0;
    endtask

    // Reset held across an edge with live requests on the inputs; all outputs must stay quiet.
    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        specPush_i = 1'b1; specPushAddr_i = 32'hDEAD; specPop_i = 1'b0;
        archPush_i = 1'b0; archPushAddr_i = '0; archPop_i = 1'b0;
        recover_i = 1'b1;
        push_rst_exp();
    endtask

    // Reset dropped between edges in the middle of a push: zeros before any further clock edge.
    task automatic reset_async(input logic [31:0] a);
        @(posedge clk);
        #1;
        specPush_i = 1'b1; specPushAddr_i = a; specPop_i = 1'b0;
        archPush_i = 1'b0; archPop_i = 1'b0; recover_i = 1'b0;
        #2;
        reset = 1'b0;
        push_rst_exp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // basic push / pop / replace-top
        do_reset();
        spush(32'h100, 0, 0, 1, 32'h0);
        spush(32'h200, 1, 1, 2, 32'h100);
        spush(32'h300, 2, 2, 3, 32'h200);
        idle(3, 3, 32'h300);
        spop(3, 3, 32'h300);
        spop(2, 2, 32'h200);
        step(1, 32'h444, 1, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 32'h100);
        idle(1, 1, 32'h444);

        // wrap-around and count saturation
        do_reset();
        for (int i = 0; i < 17; i++)
            spush(32'h1000 + 32'(i), 4'(i), 5'(i), 4'(i + 1), (i == 0) ? 32'h0 : 32'h1000 + 32'(i) - 32'd1);
        idle(1, 16, 32'h1010);
        spop(1, 16, 32'h1010);
        idle(0, 15, 32'h100F);

        // recovery onto architectural state
        do_reset();
        step(0, 0, 0, 1, 32'hA0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0);
        spush(32'hB0, 0, 0, 1, 32'h0);
        spush(32'hC0, 1, 1, 2, 32'hB0);
        step(1, 32'hD0, 0, 0, 0, 0, 1, 2, 2, 0, 0, 0, 0, 32'h0);
        idle(1, 1, 32'h0);
        idle(1, 1, 32'hA0);
        step(0, 0, 0, 1, 32'hA5, 1, 0, 1, 1, 0, 0, 1, 1, 32'hA0);
        step(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 32'h0);
        idle(1, 1, 32'h0);
        idle(1, 1, 32'hA5);
        step(0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 32'hA5);
        step(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 32'h0);
        idle(0, 0, 32'h0);
        idle(0, 0, 32'h0);

        // pop on empty stack
        do_reset();
        spop(0, 0, 32'h0);
        idle(EMPTY_POP_TOS, 0, 32'h0);
        spush(32'h55, EMPTY_POP_TOS, 0, EMPTY_POP_TOS + 4'd1, 32'h0);
        idle(EMPTY_POP_TOS + 4'd1, 1, 32'h55);

        // asynchronous reset mid-push, then normal operation on first edge after release
        reset_async(32'h66);
        spush(32'h77, 0, 0, 1, 32'h0);
        idle(1, 1, 32'h77);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        @(posedge clk);
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/ras_ctrl.md
# ras_ctrl

Return-address-stack pointer controller that sits directly in front of the RAS storage array. It tracks a speculative top-of-stack for fetch-time call/return prediction and an architectural top-of-stack for commit-time call/return, and drives the array's read port, speculative write port (port 0), architectural/checkpoint write port (port 1) and recover flag. On a branch-misprediction recovery it collapses speculative state onto architectural state in one cycle.

## Interface

- DEPTH, 16, number of stack entries (power of two)
- INDEX, 4, log2(DEPTH), pointer width
- WIDTH, 32, return-address width
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- specPush_i  in  1  fetch predicted a call this cycle
- specPushAddr_i  in  WIDTH  return address to push (call PC + 4)
- specPop_i  in  1  fetch predicted a return this cycle
- archPush_i  in  1  committed call
- archPushAddr_i  in  WIDTH  committed return address
- archPop_i  in  1  committed return
- recover_i  in  1  misprediction recovery request
- ramData_i  in  WIDTH  array read data (from addr0)
- rasAddr0_o  out  INDEX  array read address = speculative TOS
- rasAddr0wr_o / rasData0wr_o / rasWe0_o  out  INDEX / WIDTH / 1  speculative write port
- rasAddr1wr_o / rasData1wr_o / rasWe1_o  out  INDEX / WIDTH / 1  architectural write port
- rasRecover_o  out  1  array recover flag
- predTarget_o  out  WIDTH  predicted return target
- predValid_o  out  1  predTarget_o usable
- specCount_o  out  INDEX+1  speculative occupancy

## Operation

- State: specTos, archTos (INDEX bits, modulo DEPTH); specCnt, archCnt (INDEX+1 bits, 0..DEPTH).
- Spec push only: specTos+1; rasWe0_o=1, rasAddr0wr_o=specTos+1, rasData0wr_o=specPushAddr_i; specCnt=min(specCnt+1, DEPTH) (overflow overwrites oldest, wrap-around).
- Spec pop only: specTos-1; specCnt-1 (saturates at 0).
- Spec push+pop same cycle: replace top: write at specTos, specTos unchanged, specCnt=max(specCnt,1).
- Arch push/pop/both: identical rules on archTos/archCnt using port 1 (rasWe1_o, writes array and checkpoint).
- recover_i: rasRecover_o=1 (combinational pass-through); specTos<=archTos, specCnt<=archCnt; spec ops that cycle ignored and rasWe0_o=0. archPush_i/archPop_i are low whenever recover_i is high (commit interface rule; bench asserts); rasWe1_o forced 0 in that cycle.
- predTarget_o = ramData_i; predValid_o = (specCnt!=0) & !recover_i & !recoverDly, where recoverDly is recover_i registered one cycle.
- rasAddr0_o = specTos.

## Timing

- Reset (reset=0, async): specTos=archTos=0, specCnt=archCnt=0, recoverDly=0; all write enables 0, rasRecover_o=0, predValid_o=0, specCount_o=0.
- Write-port outputs are combinational from current inputs and pointers; pointer/count updates visible next cycle.
- Push in cycle N: pushed address readable on predTarget_o in N+1.
- Recover in cycle N: array restored at end of N; predValid_o low in N and N+1; spec ops accepted again from N+1.
- Reset released mid-stream: state already cleared; first edge after deassertion processes inputs normally.

## Configuration

- RAS_UNDERFLOW_GUARD_EN defined: pop with count==0 leaves TOS and count unchanged (spec and arch); predValid_o additionally requires specCnt!=0.
- Undefined: pointers move on every pop regardless of count (pure circular stack), count still saturates at 0, predValid_o ignores specCnt (high except in recovery cycles).

## Test plan

- Reset, 3 spec pushes 0x100/0x200/0x300 -> specTos=3, rasAddr0wr_o 1,2,3, predTarget_o=0x300 next cycle, specCount_o=3.
- Pop twice -> predTarget_o=0x100, specTos=1; push+pop same cycle with 0x444 -> write addr 1, specTos stays 1, predTarget_o=0x444.
- 17 pushes on DEPTH=16 -> specTos wraps to 1, specCount_o saturates at 16, entry 1 overwritten.
- Arch push 0xA0, spec pushes 0xB0/0xC0, recover -> rasRecover_o=1, predValid_o low two cycles, then specTos=archTos=1, predTarget_o=0xA0.
- Pop on empty with guard -> specTos stays 0, predValid_o=0; without guard -> specTos=15.
- Assert reset low mid-push sequence -> all outputs zero immediately, asynchronously.
